prog_counter_seq: RTL
=====================

PROG_COUNTER_SEQ -- requirements
Module: prog_counter_seq

Interface
REQ-001 Parameter PC_WIDTH, default 4: width of the PC in bits, range 2..16.
REQ-002 Parameter PC_LAST, default 15: last valid address; the counter wraps after this value.
REQ-003 Parameter RESET_ADDR, default 0: address loaded on reset and on wrap.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-006 Port stall, input, 1: hold the PC this cycle.
REQ-007 Port load, input, 1: jump request; PC takes load_addr.
REQ-008 Port load_addr, input, PC_WIDTH: jump target.
REQ-009 Port halt_req, input, 1: enter HALT.
REQ-010 Port resume, input, 1: leave HALT.
REQ-011 Port PC, output, PC_WIDTH: current address, registered.
REQ-012 Port pc_valid, output, 1: high while in RUN and the PC advanced or was loaded this cycle.
REQ-013 Port wrapped, output, 1: one-cycle pulse when an increment from PC_LAST occurs.
REQ-014 Port load_err, output, 1: one-cycle pulse when a load is rejected.
REQ-015 Port halted, output, 1: high while in HALT.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and HALT, encoded in 2 bits.
REQ-017 IDLE -> RUN on the next edge unless halt_req=1, in which case IDLE -> HALT; PC holds RESET_ADDR in IDLE.
REQ-018 In RUN, priority SHALL be halt_req > load > stall > increment, evaluated each cycle.
REQ-019 RUN increment: PC <= PC+1 when PC != PC_LAST; otherwise PC <= RESET_ADDR and wrapped=1 in the same cycle as the new PC.
REQ-020 RUN load: if load_addr <= PC_LAST then PC <= load_addr; otherwise PC holds and load_err=1 for one cycle.
REQ-021 RUN stall: PC holds and pc_valid=0.
REQ-022 RUN halt_req: enter HALT; PC holds; any simultaneous load or stall is ignored.
REQ-023 HALT: PC holds; load is accepted with the REQ-020 rules and the block stays in HALT; resume=1 -> RUN on the next edge; halt_req has priority over resume.
REQ-024 All outputs SHALL be registered; the PC update latency is one clock after the request.
REQ-025 Arithmetic SHALL be PC_WIDTH-bit unsigned and never exceed PC_LAST.

Reset
REQ-026 When reset=0, asynchronously: PC=RESET_ADDR, state=IDLE, pc_valid=0, wrapped=0, load_err=0, halted=0.
REQ-027 Reset asserted mid-operation (any state) SHALL abort the operation immediately; no pending load survives.
REQ-028 Release of reset SHALL be synchronised by the system; the first edge after release is spent in IDLE.

Configuration
REQ-029 With macro PROG_COUNTER_LINK_EN defined: ports call (input, 1), ret (input, 1) and link (output, PC_WIDTH) exist; call acts as a load and also stores the wrapped PC+1 in link; ret acts as a load of link; priority is halt_req > ret > call > load > stall; link resets to RESET_ADDR.
REQ-030 Without PROG_COUNTER_LINK_EN: none of these ports or the link register exist; behaviour is REQ-016..028 only.

Verification
REQ-031 Reset low, then high, free run with PC_WIDTH=4 and PC_LAST=15 -> PC 0 (IDLE), 0, 1, ... 15, 0; wrapped pulses exactly once at the 15->0 step.
REQ-032 PC_LAST=9, load_addr=12 in RUN -> PC unchanged, load_err=1 for 1 cycle; load_addr=7 -> PC=7 on the next edge.
REQ-033 At PC=5, halt_req, load and stall all high together -> HALT, PC=5, halted=1; then resume -> PC 6 one cycle after entering RUN.
REQ-034 At PC=3, reset pulled low mid-cycle -> PC=0 and halted=0 immediately, without waiting for clk.
REQ-035 PROG_COUNTER_LINK_EN defined: call to 10 at PC=4 -> PC=10, link=5; ret -> PC=5; call at PC=15 with PC_LAST=15 -> link=0.
REQ-036 In HALT, load_addr=8 -> PC=8 while halted stays 1; stall during RUN holds PC with pc_valid=0.

Source files
------------

// File: rtl/prog_counter_seq.sv
// prog_counter_seq
// Program counter sequencer with an IDLE/RUN/HALT control FSM. In RUN the PC
// increments each cycle (wrapping from PC_LAST back to RESET_ADDR), can be
// held by stall, redirected by load, or parked by halt_req. In HALT the PC
// holds but still accepts loads; resume returns to RUN.
//
// Optional feature (macro PROG_COUNTER_LINK_EN): adds call/ret and a link
// register holding the return address of the last accepted call.
//
// Parameters:
//   PC_WIDTH   - PC width in bits (2..16)
//   PC_LAST    - last valid address; increments wrap after it
//   RESET_ADDR - address taken on reset and on wrap
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous reset, active low
//   stall      - hold the PC this cycle
//   load       - jump request to load_addr
//   load_addr  - jump target
//   halt_req   - enter HALT
//   resume     - leave HALT
//   call, ret  - (PROG_COUNTER_LINK_EN only) call/return jumps
//   link       - (PROG_COUNTER_LINK_EN only) stored return address
//   PC         - current address (registered)
//   pc_valid   - PC advanced or was loaded in RUN this cycle
//   wrapped    - one-cycle pulse on the PC_LAST -> RESET_ADDR step
//   load_err   - one-cycle pulse when a jump target exceeds PC_LAST
//   halted     - high while in HALT
module prog_counter_seq #(
    parameter int PC_WIDTH   = 4,
    parameter int PC_LAST    = 15,
    parameter int RESET_ADDR = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] load_addr,
    input  logic                halt_req,
    input  logic                resume,
`ifdef PROG_COUNTER_LINK_EN
    input  logic                call,
    input  logic                ret,
    output logic [PC_WIDTH-1:0] link,
`endif
    output logic [PC_WIDTH-1:0] PC,
    output logic                pc_valid,
    output logic                wrapped,
    output logic                load_err,
    output logic                halted
);

    localparam logic [PC_WIDTH-1:0] LAST  = PC_WIDTH'(PC_LAST);
    localparam logic [PC_WIDTH-1:0] START = PC_WIDTH'(RESET_ADDR);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PC_WIDTH-1:0] pc_next;
    logic                valid_next;
    logic                wrap_next;
    logic                err_next;
    logic                at_last;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                jump_req;
    logic [PC_WIDTH-1:0] jump_addr;
    logic                jump_ok;

    // ">=" rather than "==" so a PC somehow above PC_LAST still wraps
    // instead of running on past the valid range.
    assign at_last = (PC >= LAST);
    assign pc_inc  = at_last ? START : PC + PC_WIDTH'(1);

`ifdef PROG_COUNTER_LINK_EN
    logic call_sel;
    logic capture_link;

    // Jump source selection: ret beats call beats a plain load. A call
    // jumps to load_addr just like a load does.
    always_comb begin
        jump_req  = load;
        jump_addr = load_addr;
        call_sel  = 1'b0;
        if (ret) begin
            jump_req  = 1'b1;
            jump_addr = link;
        end else if (call) begin
            jump_req = 1'b1;
            call_sel = 1'b1;
        end
    end

    // The return address is captured only when the call jump is actually
    // taken: halt_req in RUN suppresses it, a rejected target leaves it alone.
    assign capture_link = call_sel && jump_ok &&
                          ((state == RUN && !halt_req) || state == HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            link <= START;
        end else if (capture_link) begin
            link <= pc_inc;
        end
    end
`else
    assign jump_req  = load;
    assign jump_addr = load_addr;
`endif

    assign jump_ok = (jump_addr <= LAST);

    // Next-state and next-output logic. Outputs are computed here and
    // registered below so every port changes only on a clock edge.
    always_comb begin
        state_next = state;
        pc_next    = PC;
        valid_next = 1'b0;
        wrap_next  = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                pc_next    = START;
                state_next = halt_req ? HALT : RUN;
            end
            RUN: begin
                if (halt_req) begin
                    state_next = HALT;
                end else if (jump_req) begin
                    if (jump_ok) begin
                        pc_next    = jump_addr;
                        valid_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (!stall) begin
                    pc_next    = pc_inc;
                    valid_next = 1'b1;
                    wrap_next  = at_last;
                end
            end
            HALT: begin
                // Loads are honoured while parked, but pc_valid stays low
                // because the block is not running.
                if (!halt_req && resume) begin
                    state_next = RUN;
                end
                if (jump_req) begin
                    if (jump_ok) begin
                        pc_next = jump_addr;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                pc_next    = START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            PC       <= START;
            pc_valid <= 1'b0;
            wrapped  <= 1'b0;
            load_err <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_next;
            PC       <= pc_next;
            pc_valid <= valid_next;
            wrapped  <= wrap_next;
            load_err <= err_next;
            halted   <= (state_next == HALT);
        end
    end

endmodule
